// File: rtl/rv_pkg.sv
// Shared RV32 control/datapath encodings: opcodes, ALU codes, select codes, FSM states.
package rv_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

    localparam logic [SEL_W-1:0] WB_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WB_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WB_PC     = 2'd2;

    localparam logic [SEL_W-1:0] IMM_L = 2'd0;
    localparam logic [SEL_W-1:0] IMM_S = 2'd1;
    localparam logic [SEL_W-1:0] IMM_B = 2'd2;
    localparam logic [SEL_W-1:0] IMM_J = 2'd3;

    localparam logic [SEL_W-1:0] ALUA_REG = 2'd0;
    localparam logic [SEL_W-1:0] ALUA_PCC = 2'd1;
    localparam logic [SEL_W-1:0] ALUA_OUT = 2'd2;

    localparam logic [SEL_W-1:0] ALUB_REG  = 2'd0;
    localparam logic [SEL_W-1:0] ALUB_IMM  = 2'd1;
    localparam logic [SEL_W-1:0] ALUB_ONES = 2'd2;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, ILLEGAL
    } state_t;

    // Supported subset; SRAI is rejected because its immediate carries bit 10.
    function automatic logic is_legal(input logic [31:0] ir);
        logic ok;
        case (ir[6:0])
            OPC_OP:              ok = 1'b1;
            OPC_OPIMM:           ok = !(ir[14:12] == F3_SR && ir[30]);
            OPC_LOAD, OPC_STORE: ok = (ir[14:12] == F3_W);
            OPC_BRANCH:          ok = (ir[14:12] == F3_BEQ) || (ir[14:12] == F3_BNE);
            OPC_JAL:             ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode from funct3; alt (instr[30]) picks SUB/SRA only for register-register ops.
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic             is_op,
    output logic [ALU_W-1:0] alusel_c
);

    logic use_alt;

    assign use_alt = alt && is_op;

    always_comb begin
        alusel_c = ALU_ADD;
        case (funct3)
            3'b000:  alusel_c = use_alt ? ALU_SUB : ALU_ADD;
            3'b001:  alusel_c = ALU_SLL;
            3'b010:  alusel_c = ALU_SLT;
            3'b011:  alusel_c = ALU_SLTU;
            3'b100:  alusel_c = ALU_XOR;
            3'b101:  alusel_c = use_alt ? ALU_SRA : ALU_SRL;
            3'b110:  alusel_c = ALU_OR;
            default: alusel_c = ALU_AND;
        endcase
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/exec/mem/write-back and drives
// every datapath select and enable.
module rv_ctl
    import rv_pkg::*;
#(
    parameter int unsigned DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    input  logic               dmem_ready,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic               regwen,
    output logic               mdrwrite,
    output logic [SEL_W-1:0]   wbsel,
    output logic [SEL_W-1:0]   immsel,
    output logic [SEL_W-1:0]   asel,
    output logic [SEL_W-1:0]   bsel,
    output logic [ALU_W-1:0]   alusel,
    output logic               dmem_wen,
    output logic               illegal,
    output logic               retire
);

    state_t           state;
    state_t           state_next;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             legal;
    logic             taken;
    logic [ALU_W-1:0] dec_alu;
    logic             unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign legal       = is_legal(instr);
    assign taken       = (funct3 == F3_BEQ && zero) || (funct3 == F3_BNE && !zero);
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    rv_alu_dec u_alu_dec (
        .funct3   (funct3),
        .alt      (instr[30]),
        .is_op    (opcode == OPC_OP),
        .alusel_c (dec_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = legal ? EXEC : ILLEGAL;
            EXEC: begin
                case (opcode)
                    OPC_LOAD:  state_next = MEM_RD;
                    OPC_STORE: state_next = MEM_WR;
                    OPC_OP, OPC_OPIMM: state_next = WB_ALU;
                    default:   state_next = FETCH;
                endcase
            end
            MEM_RD:  state_next = dmem_ready ? WB_MEM : MEM_RD;
            MEM_WR:  state_next = dmem_ready ? FETCH : MEM_WR;
            WB_ALU:  state_next = FETCH;
            WB_MEM:  state_next = FETCH;
            ILLEGAL: state_next = ILLEGAL;
            default: state_next = FETCH;
        endcase
    end

    // Defaults make the ALU compute aluout & ~0, so aluout holds in any cycle not overriding them.
    always_comb begin
        pcsourse = PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        dmem_wen = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;
        wbsel    = WB_ALUOUT;
        immsel   = IMM_L;
        asel     = ALUA_OUT;
        bsel     = ALUB_ONES;
        alusel   = ALU_AND;
        if (!rst) begin
            case (state)
                FETCH: begin
                    irwrite = 1'b1;
                    pccen   = 1'b1;
                    pcwrite = 1'b1;
                end
                DECODE: begin
                    asel   = ALUA_PCC;
                    bsel   = ALUB_IMM;
                    alusel = ALU_ADD;
                    immsel = (opcode == OPC_JAL) ? IMM_J : IMM_B;
                end
                EXEC: begin
                    case (opcode)
                        OPC_OP: begin
                            asel   = ALUA_REG;
                            bsel   = ALUB_REG;
                            alusel = dec_alu;
                        end
                        OPC_OPIMM: begin
                            asel   = ALUA_REG;
                            bsel   = ALUB_IMM;
                            immsel = IMM_L;
                            alusel = dec_alu;
                        end
                        OPC_LOAD: begin
                            asel   = ALUA_REG;
                            bsel   = ALUB_IMM;
                            immsel = IMM_L;
                            alusel = ALU_ADD;
                        end
                        OPC_STORE: begin
                            asel   = ALUA_REG;
                            bsel   = ALUB_IMM;
                            immsel = IMM_S;
                            alusel = ALU_ADD;
                        end
                        OPC_BRANCH: begin
                            asel   = ALUA_REG;
                            bsel   = ALUB_REG;
                            alusel = ALU_SUB;
                            retire = 1'b1;
                            if (taken) begin
                                pcwrite  = 1'b1;
                                pcsourse = PC_ALU;
                            end
                        end
                        OPC_JAL: begin
                            regwen   = 1'b1;
                            wbsel    = WB_PC;
                            pcwrite  = 1'b1;
                            pcsourse = PC_ALU;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM_RD: mdrwrite = dmem_ready;
                MEM_WR: begin
                    dmem_wen = 1'b1;
                    retire   = dmem_ready;
                end
                WB_ALU: begin
                    regwen = 1'b1;
                    wbsel  = WB_ALUOUT;
                    retire = 1'b1;
                end
                WB_MEM: begin
                    regwen = 1'b1;
                    wbsel  = WB_MDR;
                    retire = 1'b1;
                end
                ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_ctl.sv
// Directed bench for rv_ctl driving a small behavioural RV32 datapath around the controller.
module tb_rv_ctl;
    import rv_pkg::*;

    logic             clk;
    logic             rst;
    logic [31:0]      instr;
    logic             zero;
    logic             dmem_ready;
    logic             pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_wen, illegal, retire;
    logic [SEL_W-1:0] wbsel, immsel, asel, bsel;
    logic [ALU_W-1:0] alusel;

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .regwen(regwen), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel), .dmem_wen(dmem_wen),
        .illegal(illegal), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    logic [31:0] ir, pc, pcc, aluout, mdr, imm, a, b, y, wb, pc_init;
    logic [31:0] regs [0:31];
    logic [31:0] reg_init [0:31];
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];
    logic        init_req;

    assign instr = ir;
    // zero is only consumed during a branch EXEC, where the ALU computes rs1 - rs2.
    assign zero = (regs[ir[19:15]] == regs[ir[24:20]]);

    always_comb begin
        case (immsel)
            IMM_L:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        endcase
        case (asel)
            ALUA_REG: a = regs[ir[19:15]];
            ALUA_PCC: a = pcc;
            default:  a = aluout;
        endcase
        case (bsel)
            ALUB_REG: b = regs[ir[24:20]];
            ALUB_IMM: b = imm;
            default:  b = 32'hFFFF_FFFF;
        endcase
        case (alusel)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = 32'd0;
        endcase
        case (wbsel)
            WB_MDR:  wb = mdr;
            WB_PC:   wb = pc;
            default: wb = aluout;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= pc_init; pcc <= 32'd0; ir <= 32'd0; aluout <= 32'd0; mdr <= 32'd0;
        end else begin
            aluout <= y;
            if (irwrite)  ir  <= imem[pc[9:2]];
            if (pccen)    pcc <= pc;
            if (pcwrite)  pc  <= (pcsourse == PC_ALU) ? aluout : pc + 32'd4;
            if (mdrwrite) mdr <= dmem[aluout[7:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) regs[i] <= reg_init[i];
            for (int i = 0; i < 64; i++) dmem[i] <= (i == 2) ? 32'hCAFE_BABE : 32'd0;
        end else begin
            if (regwen && ir[11:7] != 5'd0) regs[ir[11:7]] <= wb;
            if (dmem_wen && dmem_ready) dmem[aluout[7:2]] <= regs[ir[24:20]];
        end
    end

    // {pcwrite, pcsourse, pccen, irwrite, regwen, mdrwrite, dmem_wen, retire, illegal}
    localparam logic [8:0] EN_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] EN_FETCH = 9'b1_0_1_1_0_0_0_0_0;
    localparam logic [8:0] EN_WB    = 9'b0_0_0_0_1_0_0_1_0;
    localparam logic [8:0] EN_TAKEN = 9'b1_1_0_0_0_0_0_1_0;
    localparam logic [8:0] EN_RET   = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] EN_JAL   = 9'b1_1_0_0_1_0_0_1_0;
    localparam logic [8:0] EN_MDR   = 9'b0_0_0_0_0_1_0_0_0;
    localparam logic [8:0] EN_WEN   = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] EN_WRET  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] EN_ILL   = 9'b0_0_0_0_0_0_0_0_1;

    int checks;
    int passes;

    function automatic logic [8:0] en();
        return {pcwrite, pcsourse, pccen, irwrite, regwen, mdrwrite, dmem_wen, retire, illegal};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 32; i++) reg_init[i] = 32'd0;
    endtask

    // Hold reset across one edge (loading registers/memory), release, and land in cycle 1 (FETCH).
    task automatic start_prog(input logic [31:0] pc0);
        rst = 1'b1; dmem_ready = 1'b1; pc_init = pc0; init_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_req = 1'b0; rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_regs();
        reg_init[5] = 32'h5555_5555;
        imem[0] = 32'h0080_2283;
        rst = 1'b1; dmem_ready = 1'b1; pc_init = 32'd0; init_req = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (en() !== EN_NONE) $display("FAIL reset_enables: got %b want %b", en(), EN_NONE);
        else passes++;
        @(negedge clk);
        init_req = 1'b0; rst = 1'b0; #1;
        checks++;
        if (en() !== EN_FETCH) $display("FAIL reset_first_fetch: got %b want %b", en(), EN_FETCH);
        else passes++;
        step(); step();
        dmem_ready = 1'b0;
        step();
        checks++;
        if (en() !== EN_NONE || aluout !== 32'd8)
            $display("FAIL reset_mrd_wait: en=%b aluout=%h want en=%b aluout=8", en(), aluout, EN_NONE);
        else passes++;
        rst = 1'b1; #1;
        checks++;
        if (en() !== EN_NONE) $display("FAIL reset_mid_load: got %b want %b", en(), EN_NONE);
        else passes++;
        dmem_ready = 1'b1;
        step();
        checks++;
        if (en() !== EN_NONE) $display("FAIL reset_held_ready: got %b want %b", en(), EN_NONE);
        else passes++;
        rst = 1'b0; #1;
        checks++;
        if (en() !== EN_FETCH) $display("FAIL reset_release_fetch: got %b want %b", en(), EN_FETCH);
        else passes++;
        step(); step();
        checks++;
        if (regs[5] !== 32'h5555_5555) $display("FAIL reset_no_write: x5=%h want 55555555", regs[5]);
        else passes++;
    endtask

    typedef struct {
        logic [31:0]      ins;
        logic [31:0]      r1;
        logic [31:0]      r2;
        int               rd;
        logic [ALU_W-1:0] alu;
        logic [31:0]      val;
        bit               is_imm;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t v [4];
        v[0] = '{32'h0020_81B3, 32'd5, 32'd7, 3, ALU_ADD, 32'd12, 1'b0};
        v[1] = '{32'h4020_81B3, 32'd5, 32'd7, 3, ALU_SUB, 32'hFFFF_FFFE, 1'b0};
        v[2] = '{32'h4020_D1B3, 32'hFFFF_FFF0, 32'd2, 3, ALU_SRA, 32'hFFFF_FFFC, 1'b0};
        v[3] = '{32'h0F00_E213, 32'd5, 32'd0, 4, ALU_OR, 32'h0000_00F5, 1'b1};
        for (int k = 0; k < 4; k++) begin
            clear_regs();
            reg_init[1] = v[k].r1; reg_init[2] = v[k].r2;
            imem[0] = v[k].ins;
            start_prog(32'd0);
            checks++;
            if (en() !== EN_FETCH) $display("FAIL alu_fetch[%0d]: got %b want %b", k, en(), EN_FETCH);
            else passes++;
            step();
            checks++;
            if (en() !== EN_NONE || asel !== ALUA_PCC || bsel !== ALUB_IMM || alusel !== ALU_ADD || immsel !== IMM_B)
                $display("FAIL alu_decode[%0d]: en=%b asel=%0d bsel=%0d alusel=%0d immsel=%0d want en=0 asel=1 bsel=1 alusel=0 immsel=2",
                         k, en(), asel, bsel, alusel, immsel);
            else passes++;
            step();
            checks++;
            if (en() !== EN_NONE || alusel !== v[k].alu || asel !== ALUA_REG ||
                bsel !== (v[k].is_imm ? ALUB_IMM : ALUB_REG))
                $display("FAIL alu_exec[%0d]: en=%b alusel=%0d asel=%0d bsel=%0d want alusel=%0d",
                         k, en(), alusel, asel, bsel, v[k].alu);
            else passes++;
            step();
            checks++;
            if (en() !== EN_WB || wbsel !== WB_ALUOUT)
                $display("FAIL alu_wb[%0d]: en=%b wbsel=%0d want en=%b wbsel=0", k, en(), wbsel, EN_WB);
            else passes++;
            step();
            checks++;
            if (en() !== EN_FETCH || regs[v[k].rd] !== v[k].val)
                $display("FAIL alu_result[%0d]: en=%b rd=%h want en=%b rd=%h", k, en(), regs[v[k].rd], EN_FETCH, v[k].val);
            else passes++;
        end
    endtask

    task automatic test_load_wait();
        clear_regs();
        imem[0] = 32'h0080_2283;
        start_prog(32'd0);
        step(); step();
        checks++;
        if (en() !== EN_NONE || asel !== ALUA_REG || bsel !== ALUB_IMM || immsel !== IMM_L || alusel !== ALU_ADD)
            $display("FAIL load_exec: en=%b asel=%0d bsel=%0d immsel=%0d alusel=%0d", en(), asel, bsel, immsel, alusel);
        else passes++;
        dmem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (en() !== EN_NONE || aluout !== 32'd8)
                $display("FAIL load_wait[%0d]: en=%b aluout=%h want en=%b aluout=8", c, en(), aluout, EN_NONE);
            else passes++;
        end
        step();
        dmem_ready = 1'b1; #1;
        checks++;
        if (en() !== EN_MDR || aluout !== 32'd8)
            $display("FAIL load_ready: en=%b aluout=%h want en=%b aluout=8", en(), aluout, EN_MDR);
        else passes++;
        step();
        checks++;
        if (en() !== EN_WB || wbsel !== WB_MDR)
            $display("FAIL load_wb: en=%b wbsel=%0d want en=%b wbsel=1", en(), wbsel, EN_WB);
        else passes++;
        step();
        checks++;
        if (en() !== EN_FETCH || regs[5] !== 32'hCAFE_BABE)
            $display("FAIL load_result: en=%b x5=%h want en=%b x5=cafebabe", en(), regs[5], EN_FETCH);
        else passes++;
    endtask

    task automatic test_store_wait();
        clear_regs();
        reg_init[1] = 32'd8; reg_init[2] = 32'h0000_1234;
        imem[0] = 32'h0020_A223;
        start_prog(32'd0);
        step(); step();
        checks++;
        if (en() !== EN_NONE || immsel !== IMM_S || bsel !== ALUB_IMM || alusel !== ALU_ADD)
            $display("FAIL store_exec: en=%b immsel=%0d bsel=%0d alusel=%0d", en(), immsel, bsel, alusel);
        else passes++;
        dmem_ready = 1'b0;
        step();
        checks++;
        if (en() !== EN_WEN || aluout !== 32'd12)
            $display("FAIL store_wait: en=%b aluout=%h want en=%b aluout=c", en(), aluout, EN_WEN);
        else passes++;
        dmem_ready = 1'b1; #1;
        checks++;
        if (en() !== EN_WRET) $display("FAIL store_ready: got %b want %b", en(), EN_WRET);
        else passes++;
        step();
        checks++;
        if (en() !== EN_FETCH || dmem[3] !== 32'h0000_1234)
            $display("FAIL store_result: en=%b mem=%h want en=%b mem=00001234", en(), dmem[3], EN_FETCH);
        else passes++;
    endtask

    task automatic test_branch();
        logic [31:0] ins  [2];
        logic [8:0]  ex   [2];
        logic [31:0] npc  [2];
        ins[0] = 32'h0000_0863; ex[0] = EN_TAKEN; npc[0] = 32'h110;
        ins[1] = 32'h0000_1863; ex[1] = EN_RET;   npc[1] = 32'h104;
        for (int k = 0; k < 2; k++) begin
            clear_regs();
            imem[64] = ins[k];
            start_prog(32'h100);
            step();
            checks++;
            if (immsel !== IMM_B || asel !== ALUA_PCC)
                $display("FAIL branch_decode[%0d]: immsel=%0d asel=%0d want 2 1", k, immsel, asel);
            else passes++;
            step();
            checks++;
            if (en() !== ex[k] || alusel !== ALU_SUB || asel !== ALUA_REG || bsel !== ALUB_REG)
                $display("FAIL branch_exec[%0d]: en=%b alusel=%0d want en=%b alusel=1", k, en(), alusel, ex[k]);
            else passes++;
            step();
            checks++;
            if (en() !== EN_FETCH || pc !== npc[k])
                $display("FAIL branch_pc[%0d]: en=%b pc=%h want en=%b pc=%h", k, en(), pc, EN_FETCH, npc[k]);
            else passes++;
        end
    endtask

    task automatic test_jal();
        clear_regs();
        imem[16] = 32'h0200_00EF;
        start_prog(32'h40);
        step();
        checks++;
        if (immsel !== IMM_J || asel !== ALUA_PCC || bsel !== ALUB_IMM)
            $display("FAIL jal_decode: immsel=%0d asel=%0d bsel=%0d want 3 1 1", immsel, asel, bsel);
        else passes++;
        step();
        checks++;
        if (en() !== EN_JAL || wbsel !== WB_PC)
            $display("FAIL jal_exec: en=%b wbsel=%0d want en=%b wbsel=2", en(), wbsel, EN_JAL);
        else passes++;
        step();
        checks++;
        if (en() !== EN_FETCH || regs[1] !== 32'h44 || pc !== 32'h60)
            $display("FAIL jal_result: en=%b x1=%h pc=%h want en=%b x1=44 pc=60", en(), regs[1], pc, EN_FETCH);
        else passes++;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        bad[0] = 32'h0000_007F;
        bad[1] = 32'h4030_D093;
        bad[2] = 32'h0000_0283;
        bad[3] = 32'h0000_4863;
        for (int k = 0; k < 4; k++) begin
            clear_regs();
            imem[0] = bad[k];
            start_prog(32'd0);
            step();
            checks++;
            if (en() !== EN_NONE) $display("FAIL illegal_decode[%0d]: got %b want %b", k, en(), EN_NONE);
            else passes++;
            step();
            checks++;
            if (en() !== EN_ILL) $display("FAIL illegal_enter[%0d]: got %b want %b", k, en(), EN_ILL);
            else passes++;
            step(); step(); step();
            checks++;
            if (en() !== EN_ILL) $display("FAIL illegal_hold[%0d]: got %b want %b", k, en(), EN_ILL);
            else passes++;
        end
    endtask

    initial begin
        checks = 0; passes = 0;
        rst = 1'b1; dmem_ready = 1'b1; init_req = 1'b0; pc_init = 32'd0;
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        clear_regs();
        test_reset();
        test_alu_ops();
        test_load_wait();
        test_store_wait();
        test_branch();
        test_jal();
        test_illegal();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
